// File: rtl/freq_mon_ctrl_pkg.sv
// Shared types and defaults for the 5 MHz frequency-monitor sequencer.
// Nominal: 1000 counts of the 5 MHz test clock over a 10001-cycle 50 MHz gate.
package freq_mon_ctrl_pkg;

    localparam int CNT_W     = 16;
    localparam int NOM_COUNT = 1000;
    localparam int GATE_CYC  = 10001;

    localparam int DEF_TRIG_LEN   = 2;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_GAP_CYC    = 1000;
    localparam int DEF_TIMEOUT    = GATE_CYC + 1999;
    localparam int DEF_WIN_LO     = NOM_COUNT - 10;
    localparam int DEF_WIN_HI     = NOM_COUNT + 10;
    localparam int DEF_FAULT_N    = 3;

    // Retry index at which a further CHECK mismatch is treated as instability.
    localparam int RETRY_W   = 2;
    localparam int RETRY_MAX = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRIG     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_SAMPLE   = 3'd4,
        ST_CHECK    = 3'd5,
        ST_EVAL     = 3'd6,
        ST_GAP      = 3'd7
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/freq_mon_ctrl_avg4.sv
// Four-deep history of accepted counts with a running 18-bit sum.
// An empty history is filled entirely by the first sample it receives.
module freq_avg4
    import freq_mon_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_sample,
    output logic [CNT_W-1:0] o_avg
);

    logic [CNT_W-1:0] r_hist [4];
    logic [CNT_W+1:0] r_sum;
    logic             r_empty;

    // A clear coinciding with a load empties first, so the sample refills all entries.
    always_ff @(posedge clk) begin
        if (rst || (i_clr && !i_load)) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_sum   <= '0;
            r_empty <= 1'b1;
        end else if (i_load) begin
            if (r_empty || i_clr) begin
                for (int i = 0; i < 4; i++) r_hist[i] <= i_sample;
                r_sum   <= {i_sample, 2'b00};
                r_empty <= 1'b0;
            end else begin
                r_hist[0] <= i_sample;
                for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
                r_sum <= r_sum - {2'b00, r_hist[3]} + {2'b00, i_sample};
            end
        end
    end

    assign o_avg = r_sum[CNT_W+1:2];

endmodule

// File: rtl/freq_mon_ctrl.sv
// Measurement sequencer for the 5 MHz frequency counter: trigger, wait for
// ready, double-sample the count, window-check it, average it, track faults.
module freq_mon_ctrl
    import freq_mon_ctrl_pkg::*;
#(
    parameter int TRIG_LEN   = DEF_TRIG_LEN,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int WIN_LO     = DEF_WIN_LO,
    parameter int WIN_HI     = DEF_WIN_HI,
    parameter int FAULT_N    = DEF_FAULT_N
) (
    input  logic             s_clk,
    input  logic             arst,
    input  logic             enable,
    input  logic             fault_clr,
    output logic             meas_trig,
    input  logic             cnt_ready,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_value,
    output logic [CNT_W-1:0] meas_avg,
    output logic             in_window,
    output logic             freq_fault,
    output logic             timeout_err,
    output logic [2:0]       dbg_state
);

    localparam int TMR_MAX = max_int(max_int(TRIG_LEN, SETTLE_CYC), max_int(GAP_CYC, TIMEOUT));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FC_W    = $clog2(FAULT_N + 1);

    state_t             r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
    logic [RETRY_W-1:0] r_retry, w_retry_nxt;
    logic [CNT_W-1:0]   r_s0;
    logic               w_s0_load, w_accept, w_tmo, w_in_win, w_bad;
    logic [FC_W-1:0]    r_consec, w_consec_nxt;
    logic               r_fault, r_tmo_err, r_in_win;
    logic [CNT_W-1:0]   r_value, w_avg;

    always_ff @(posedge s_clk) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_retry <= '0;
            r_s0    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_retry <= w_retry_nxt;
            if (w_s0_load) r_s0 <= cnt_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + TMR_W'(1);
        w_retry_nxt = r_retry;
        w_s0_load   = 1'b0;
        w_accept    = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_nxt   = '0;
                w_retry_nxt = '0;
                if (enable) w_state_nxt = ST_TRIG;
            end
            ST_TRIG: begin
                w_retry_nxt = '0;
                if (r_tmr == TMR_W'(TRIG_LEN - 1)) begin
                    w_state_nxt = ST_WAIT_RDY;
                    w_tmr_nxt   = '0;
                end
            end
            ST_WAIT_RDY: begin
                if (cnt_ready) begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_nxt   = '0;
                end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_GAP;
                    w_tmr_nxt   = '0;
                    w_tmo       = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_tmr == TMR_W'(SETTLE_CYC - 1)) begin
                    w_state_nxt = ST_SAMPLE;
                    w_tmr_nxt   = '0;
                end
            end
            ST_SAMPLE: begin
                w_s0_load   = 1'b1;
                w_state_nxt = ST_CHECK;
                w_tmr_nxt   = '0;
            end
            // cnt_in crosses from the test-clock domain; two equal looks a settle apart accept it.
            ST_CHECK: begin
                w_tmr_nxt = '0;
                if (cnt_in == r_s0) begin
                    w_state_nxt = ST_EVAL;
                    w_accept    = 1'b1;
                end else if (r_retry == RETRY_W'(RETRY_MAX)) begin
                    w_state_nxt = ST_GAP;
                    w_tmo       = 1'b1;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_retry_nxt = r_retry + RETRY_W'(1);
                end
            end
            ST_EVAL: begin
                w_state_nxt = ST_GAP;
                w_tmr_nxt   = '0;
            end
            ST_GAP: begin
                if (r_tmr == TMR_W'(GAP_CYC - 1)) begin
                    w_state_nxt = enable ? ST_TRIG : ST_IDLE;
                    w_tmr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    assign w_in_win = (r_s0 >= CNT_W'(WIN_LO)) && (r_s0 <= CNT_W'(WIN_HI));
    assign w_bad    = w_tmo || (w_accept && !w_in_win);

    always_comb begin
        w_consec_nxt = '0;
        if (w_bad) begin
            w_consec_nxt = r_consec;
            if (r_consec != FC_W'(FAULT_N)) w_consec_nxt = r_consec + FC_W'(1);
        end
    end

    // Results load on the CHECK->EVAL edge so they are already valid during EVAL.
    always_ff @(posedge s_clk) begin
        if (arst) begin
            r_value   <= '0;
            r_in_win  <= 1'b0;
            r_consec  <= '0;
            r_fault   <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_value  <= r_s0;
                r_in_win <= w_in_win;
            end
            if (fault_clr) begin
                r_consec  <= '0;
                r_fault   <= 1'b0;
                r_tmo_err <= 1'b0;
            end else begin
                if (w_tmo) r_tmo_err <= 1'b1;
                if (w_accept || w_tmo) begin
                    r_consec <= w_consec_nxt;
                    if (w_consec_nxt == FC_W'(FAULT_N)) r_fault <= 1'b1;
                end
            end
        end
    end

    freq_avg4 u_avg (
        .clk      (s_clk),
        .rst      (arst),
        .i_load   (w_accept),
        .i_clr    (fault_clr),
        .i_sample (r_s0),
        .o_avg    (w_avg)
    );

    // meas_valid is a one-cycle strobe with no back-pressure; cnt_ready is a level
    // that the counter holds until the next meas_trig.
    assign meas_trig   = (r_state == ST_TRIG);
    assign meas_valid  = (r_state == ST_EVAL);
    assign meas_value  = r_value;
    assign meas_avg    = w_avg;
    assign in_window   = r_in_win;
    assign freq_fault  = r_fault;
    assign timeout_err = r_tmo_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_freq_mon_ctrl.sv
// Directed bench for freq_mon_ctrl: a behavioural counter drives ready/count,
// and a scoreboard queue holds the expected result of every measurement.
module tb_freq_mon_ctrl;

    localparam int TRIG_LEN   = 2;
    localparam int SETTLE_CYC = 8;
    localparam int TIMEOUT    = 12000;
    localparam int WIN_LO     = 990;
    localparam int WIN_HI     = 1010;
    localparam int FAULT_N    = 3;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd7;

    // clock / reset
    logic        s_clk = 1'b0;
    logic        arst = 1'b1;
    logic        enable = 1'b0;
    logic        fault_clr = 1'b0;
    logic        cnt_ready = 1'b0;
    logic [15:0] cnt_in = '0;
    logic        meas_trig, meas_valid, in_window, freq_fault, timeout_err;
    logic [15:0] meas_value, meas_avg;
    logic [2:0]  dbg_state;

    always #10 s_clk = ~s_clk;

    freq_mon_ctrl dut (
        .s_clk       (s_clk),
        .arst        (arst),
        .enable      (enable),
        .fault_clr   (fault_clr),
        .meas_trig   (meas_trig),
        .cnt_ready   (cnt_ready),
        .cnt_in      (cnt_in),
        .meas_valid  (meas_valid),
        .meas_value  (meas_value),
        .meas_avg    (meas_avg),
        .in_window   (in_window),
        .freq_fault  (freq_fault),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // scoreboard: {timeout_err, freq_fault, in_window, meas_avg, meas_value}
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [34:0] exp_q[$];
    int          m_consec = 0;
    bit          m_fault = 0;
    bit          m_tmo = 0;
    bit          m_empty = 1;
    int          m_hist[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_bad();
        if (m_consec < FAULT_N) m_consec++;
        if (m_consec == FAULT_N) m_fault = 1;
    endtask

    task automatic model_accept(input logic [15:0] val, input bit clr);
        bit win;
        int sum;
        win = (val >= WIN_LO) && (val <= WIN_HI);
        if (clr) begin
            m_consec = 0; m_fault = 0; m_tmo = 0; m_empty = 1;
        end else if (win) begin
            m_consec = 0;
        end else begin
            model_bad();
        end
        if (m_empty) begin
            for (int i = 0; i < 4; i++) m_hist[i] = val;
            m_empty = 0;
        end else begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = val;
        end
        sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
        exp_q.push_back({m_tmo, m_fault, win, 16'(sum / 4), val});
    endtask

    task automatic model_reset();
        m_consec = 0; m_fault = 0; m_tmo = 0; m_empty = 1;
    endtask

    // driver tasks
    task automatic check_reset(input string tag);
        chk({tag, "_trig"}, meas_trig, 0);
        chk({tag, "_valid"}, meas_valid, 0);
        chk({tag, "_value"}, meas_value, 0);
        chk({tag, "_avg"}, meas_avg, 0);
        chk({tag, "_inwin"}, in_window, 0);
        chk({tag, "_fault"}, freq_fault, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
        chk({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    task automatic pulse_clr();
        @(negedge s_clk);
        fault_clr = 1'b1;
        @(negedge s_clk);
        fault_clr = 1'b0;
        model_reset();
        chk("clr_fault", freq_fault, 0);
        chk("clr_tmo", timeout_err, 0);
    endtask

    task automatic wait_trig();
        int n;
        n = 0;
        while (meas_trig !== 1'b1 && n < 3000) begin
            @(negedge s_clk);
            n++;
        end
        chk("trig_rise", meas_trig, 1);
        cnt_ready = 1'b0;
        n = 0;
        while (meas_trig !== 1'b0 && n < 10) begin
            @(negedge s_clk);
            n++;
        end
        chk("trig_len", n, TRIG_LEN);
    endtask

    task automatic do_meas(input logic [15:0] val, input int dly, input bit clr_at_chk);
        int n;
        logic [34:0] e;
        wait_trig();
        cnt_in = val;
        model_accept(val, clr_at_chk);
        repeat (dly) @(negedge s_clk);
        cnt_ready = 1'b1;
        n = 0;
        do begin
            @(negedge s_clk);
            n++;
            if (fault_clr) fault_clr = 1'b0;
            if (clr_at_chk && dbg_state === S_CHECK) fault_clr = 1'b1;
        end while (meas_valid !== 1'b1 && n < 100);
        fault_clr = 1'b0;
        chk("valid_lat", n, SETTLE_CYC + 3);
        e = exp_q.pop_front();
        chk("value", meas_value, e[15:0]);
        chk("avg", meas_avg, e[31:16]);
        chk("in_window", in_window, e[32]);
        chk("freq_fault", freq_fault, e[33]);
        chk("timeout_err", timeout_err, e[34]);
        @(negedge s_clk);
        chk("valid_pulse", meas_valid, 0);
    endtask

    task automatic do_timeout();
        int n;
        bit seen;
        wait_trig();
        model_bad();
        m_tmo = 1;
        n = 0;
        seen = 0;
        while (timeout_err !== 1'b1 && n < TIMEOUT + 100) begin
            @(negedge s_clk);
            n++;
            if (meas_valid === 1'b1) seen = 1;
        end
        chk("tmo_cycles", n, TIMEOUT);
        chk("tmo_state", dbg_state, S_GAP);
        chk("tmo_no_valid", seen, 0);
        chk("tmo_fault", freq_fault, m_fault);
    endtask

    task automatic do_unstable(input logic [15:0] val);
        int n;
        bit seen;
        wait_trig();
        cnt_in = val;
        model_bad();
        m_tmo = 1;
        repeat (20) @(negedge s_clk);
        cnt_ready = 1'b1;
        n = 0;
        seen = 0;
        do begin
            @(negedge s_clk);
            n++;
            if (meas_valid === 1'b1) seen = 1;
            if (timeout_err !== 1'b1) cnt_in = cnt_in + 16'd1;
        end while (timeout_err !== 1'b1 && n < 200);
        chk("unst_cycles", n, 4 * (SETTLE_CYC + 2) + 1);
        chk("unst_state", dbg_state, S_GAP);
        chk("unst_no_valid", seen, 0);
        chk("unst_tmo", timeout_err, m_tmo);
    endtask

    task automatic do_arst();
        wait_trig();
        repeat (5) @(negedge s_clk);
        chk("arst_pre_state", dbg_state, S_WAIT);
        arst = 1'b1;
        @(negedge s_clk);
        check_reset("arst");
        model_reset();
        arst = 1'b0;
        @(negedge s_clk);
        chk("arst_retrig", meas_trig, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge s_clk);
        @(negedge s_clk);
        check_reset("rst");
        arst = 1'b0;
        enable = 1'b1;
        @(negedge s_clk);
        chk("first_trig", meas_trig, 1);

        // nominal, then the running-average sequence
        do_meas(16'd1000, 10001, 0);
        do_meas(16'd1004, 20, 0);
        do_meas(16'd1008, 20, 0);
        do_meas(16'd1012, 20, 0);

        // window boundaries
        do_meas(16'd990, 20, 0);
        do_meas(16'd1010, 20, 0);
        do_meas(16'd989, 20, 0);
        do_meas(16'd1011, 20, 0);

        // consecutive faults, with an in-window result breaking the run
        pulse_clr();
        do_meas(16'd1200, 20, 0);
        do_meas(16'd1200, 20, 0);
        do_meas(16'd1000, 20, 0);
        do_meas(16'd1200, 20, 0);
        do_meas(16'd1200, 20, 0);
        do_meas(16'd1200, 20, 0);

        // fault_clr on the same edge that would set the fault
        pulse_clr();
        do_meas(16'd1200, 20, 0);
        do_meas(16'd1200, 20, 0);
        do_meas(16'd1200, 20, 1);

        pulse_clr();
        do_timeout();
        pulse_clr();
        do_unstable(16'd1000);

        do_arst();
        do_meas(16'd1000, 20, 0);

        enable = 1'b0;
        repeat (5) @(negedge s_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/freq_mon_ctrl.md
# freq_mon_ctrl

Measurement sequencer and checker for the 5 MHz frequency counter, all in the 50 MHz reference domain.
- Periodically triggers the counter and waits for its `ready`.
- Captures the 16-bit count once it is stable, checks it against a frequency window, and keeps a 4-sample running average.
- Raises a sticky fault after consecutive out-of-window results.
- Sits directly upstream and downstream of the counter: drives its trigger/reset input and consumes `freq_cnt`/`ready`.

## Interface
Parameters:
- TRIG_LEN, 2: trigger pulse width, s_clk cycles
- SETTLE_CYC, 8: wait after ready before sampling count
- GAP_CYC, 1000: idle cycles between measurements
- TIMEOUT, 12000: max cycles from trigger release to ready
- WIN_LO, 990: lowest in-window count, inclusive
- WIN_HI, 1010: highest in-window count, inclusive
- FAULT_N, 3: consecutive out-of-window results that set the fault

Ports:
- s_clk  in  1  reference clock, 50 MHz
- arst  in  1  reset, synchronous, active-high (sampled only on s_clk rising edge)
- enable  in  1  run measurements continuously while high
- fault_clr  in  1  clears freq_fault, timeout_err and the consecutive-fault counter
- meas_trig  out  1  drives counter trigger/reset; high TRIG_LEN cycles
- cnt_ready  in  1  counter ready, s_clk domain
- cnt_in  in  16  counter value (test-clock domain, quasi-static after ready)
- meas_valid  out  1  one-cycle pulse, new result
- meas_value  out  16  last accepted count
- meas_avg  out  16  mean of last 4 accepted counts
- in_window  out  1  last result within [WIN_LO, WIN_HI]
- freq_fault  out  1  sticky fault flag
- timeout_err  out  1  sticky timeout/instability flag

## Operation
- States: IDLE, TRIG, WAIT_RDY, SETTLE, SAMPLE, CHECK, EVAL, GAP.
- IDLE: leaves for TRIG when enable=1.
- TRIG: meas_trig=1 for TRIG_LEN cycles, then WAIT_RDY.
- WAIT_RDY:
  - cnt_ready=1 → SETTLE.
  - TIMEOUT cycles elapse first → set timeout_err, go to GAP; no meas_valid.
- SETTLE: wait SETTLE_CYC cycles, then SAMPLE.
- SAMPLE: register cnt_in into s0, then CHECK.
- CHECK: compare cnt_in with s0.
  - Equal → EVAL.
  - Unequal → back to SETTLE, retry counter +1.
  - 4th mismatch → set timeout_err, go to GAP.
- EVAL: meas_value←s0 and meas_valid=1; update average and in_window; update fault logic; go to GAP.
- GAP: wait GAP_CYC cycles, then TRIG if enable=1, else IDLE.
- enable dropping mid-measurement does not abort; the current cycle completes through GAP.
- Average:
  - 4-entry history, 18-bit sum; meas_avg = sum[17:2], truncated.
  - First accepted sample after reset or fault_clr fills all 4 entries.
- Fault logic:
  - Out-of-window increments a saturating consecutive counter; in-window resets it to 0.
  - The counter reaching FAULT_N sets freq_fault.
  - A timeout counts as out-of-window.
- fault_clr:
  - Takes effect on the next edge and wins over a same-cycle set.
  - Does not disturb the FSM.
  - Resets the average history to empty.
- arst: returns to IDLE from any state on the next edge.
- Reset values: meas_trig=0, meas_valid=0, meas_value=0, meas_avg=0, in_window=0, freq_fault=0, timeout_err=0, all counters 0.

## Timing
- meas_trig rises 1 cycle after enable is sampled high in IDLE.
- The counter's ready arrives about 10002 cycles after trigger release; the default TIMEOUT covers this with margin.
- meas_valid is asserted 1 cycle after CHECK passes. With no retries:
  - meas_valid cycle = cnt_ready cycle + SETTLE_CYC + 3.
  - All result outputs update on that same edge and hold until the next EVAL.
- Full period ≈ TRIG_LEN + 10002 + SETTLE_CYC + 3 + GAP_CYC cycles.
- Window compare is unsigned and inclusive at both ends.

## Structure
- Shared package holds:
  - state enum
  - default window and timing constants: 5 MHz nominal = 1000 counts over a 10001-cycle gate
  - the 16-bit count width
- One sub-module, freq_avg4: 4-deep history with running sum, load-all and clear inputs.

## Test plan
- Nominal: cnt_in=1000, ready after 10002 cycles → meas_valid after SETTLE_CYC+3, meas_value=1000, meas_avg=1000, in_window=1.
- Boundaries:
  - cnt_in=990 and 1010 → in_window=1.
  - 989 and 1011 → in_window=0.
- Fault: three consecutive 1200 results → freq_fault=1 on the 3rd meas_valid. An intervening 1000 resets the count. fault_clr in the same cycle as a set leaves freq_fault=0.
- Average: results 1000, 1004, 1008, 1012 after reset → meas_avg 1000, 1001, 1003, 1006.
- Timeout/instability:
  - ready never asserts → timeout_err after TIMEOUT cycles, FSM reaches GAP.
  - cnt_in changing on every sample → timeout_err after the 4th mismatch, no meas_valid.
- arst asserted mid-WAIT_RDY → next edge IDLE, all outputs at reset values; with enable=1, meas_trig re-asserts 1 cycle after release.
